// File: rtl/arm_pkg.sv
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared constants for the ARM 5-stage pipeline forwarding logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_pkg;

  localparam int REG_ADDR_W = 4;

  // Operand multiplexer select codes; the mux instantiation uses these too.
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/src_match.sv
// ============================================================================
// Module   : src_match
// Brief    : Compares one source register index against two destination tags.
//            Returns o_hit = {mem_hit, wb_hit}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module src_match #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_src_vld,
  input  logic                  i_mem_en,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  output logic [1:0]            o_hit
);

  logic w_mem_hit;
  logic w_wb_hit;

  // An unused operand never matches, even when it names register 0.
  assign w_mem_hit = i_src_vld & i_mem_en & (i_src == i_mem_dest);
  assign w_wb_hit  = i_src_vld & i_wb_en  & (i_src == i_wb_dest);
  assign o_hit     = {w_mem_hit, w_wb_hit};

endmodule

`default_nettype wire

// File: rtl/forward_ctrl.sv
// ============================================================================
// Module   : forward_ctrl
// Brief    : EXE operand-mux selects and load-use hazard for the ARM pipeline.
//            Define FORWARDING_EN to enable MEM/WB forwarding; otherwise the
//            selects are tied to the register file and hazards cover EXE/MEM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_ctrl #(
  parameter int REG_ADDR_W = arm_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [REG_ADDR_W-1:0] exe_src_1,
  input  logic [REG_ADDR_W-1:0] exe_src_2,
  input  logic                  exe_src_1_vld,
  input  logic                  exe_src_2_vld,
  input  logic [REG_ADDR_W-1:0] id_src_1,
  input  logic [REG_ADDR_W-1:0] id_src_2,
  input  logic                  id_src_1_vld,
  input  logic                  id_src_2_vld,
  output logic [1:0]            sel_src_1,
  output logic [1:0]            sel_src_2,
  output logic                  hazard
);

  import arm_pkg::*;

  logic                  r_mem_wb_en;
  logic                  r_mem_mem_read;
  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic                  r_wb_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_dest;

  // Flush kills the EXE instruction but still lets WB advance; it beats freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_wb_en    <= 1'b0;
      r_mem_mem_read <= 1'b0;
      r_mem_dest     <= '0;
      r_wb_wb_en     <= 1'b0;
      r_wb_dest      <= '0;
    end else if (flush) begin
      r_mem_wb_en    <= 1'b0;
      r_mem_mem_read <= 1'b0;
      r_mem_dest     <= exe_dest;
      r_wb_wb_en     <= r_mem_wb_en;
      r_wb_dest      <= r_mem_dest;
    end else if (!freeze) begin
      r_mem_wb_en    <= exe_wb_en;
      r_mem_mem_read <= exe_mem_read;
      r_mem_dest     <= exe_dest;
      r_wb_wb_en     <= r_mem_wb_en;
      r_wb_dest      <= r_mem_dest;
    end
  end

  // ID comparators: slot "mem" checks the EXE producer, slot "wb" the MEM one.
  logic       w_id_exe_en;
  logic [1:0] w_id1_hit;
  logic [1:0] w_id2_hit;

  src_match #(.REG_ADDR_W(REG_ADDR_W)) u_id_match_1 (
    .i_src      (id_src_1),
    .i_src_vld  (id_src_1_vld),
    .i_mem_en   (w_id_exe_en),
    .i_mem_dest (exe_dest),
    .i_wb_en    (r_mem_wb_en),
    .i_wb_dest  (r_mem_dest),
    .o_hit      (w_id1_hit)
  );

  src_match #(.REG_ADDR_W(REG_ADDR_W)) u_id_match_2 (
    .i_src      (id_src_2),
    .i_src_vld  (id_src_2_vld),
    .i_mem_en   (w_id_exe_en),
    .i_mem_dest (exe_dest),
    .i_wb_en    (r_mem_wb_en),
    .i_wb_dest  (r_mem_dest),
    .o_hit      (w_id2_hit)
  );

`ifdef FORWARDING_EN
  logic       w_mem_fwd_en;
  logic [1:0] w_exe1_hit;
  logic [1:0] w_exe2_hit;
  logic       w_unused_id;

  // A load in MEM has no data yet, so it must not be forwarded from MEM.
  assign w_mem_fwd_en = r_mem_wb_en & ~r_mem_mem_read;

  src_match #(.REG_ADDR_W(REG_ADDR_W)) u_exe_match_1 (
    .i_src      (exe_src_1),
    .i_src_vld  (exe_src_1_vld),
    .i_mem_en   (w_mem_fwd_en),
    .i_mem_dest (r_mem_dest),
    .i_wb_en    (r_wb_wb_en),
    .i_wb_dest  (r_wb_dest),
    .o_hit      (w_exe1_hit)
  );

  src_match #(.REG_ADDR_W(REG_ADDR_W)) u_exe_match_2 (
    .i_src      (exe_src_2),
    .i_src_vld  (exe_src_2_vld),
    .i_mem_en   (w_mem_fwd_en),
    .i_mem_dest (r_mem_dest),
    .i_wb_en    (r_wb_wb_en),
    .i_wb_dest  (r_wb_dest),
    .o_hit      (w_exe2_hit)
  );

  assign sel_src_1 = w_exe1_hit[1] ? SEL_MEM : (w_exe1_hit[0] ? SEL_WB : SEL_REG);
  assign sel_src_2 = w_exe2_hit[1] ? SEL_MEM : (w_exe2_hit[0] ? SEL_WB : SEL_REG);

  // Only a load in EXE stalls; everything else is covered by forwarding.
  assign w_id_exe_en = exe_wb_en & exe_mem_read;
  assign hazard      = w_id1_hit[1] | w_id2_hit[1];
  assign w_unused_id = w_id1_hit[0] ^ w_id2_hit[0];
`else
  logic w_unused_fwd;

  assign sel_src_1 = SEL_REG;
  assign sel_src_2 = SEL_REG;

  // Without forwarding any in-flight producer in EXE or MEM stalls; WB is
  // safe because the register file writes in the first half-cycle.
  assign w_id_exe_en  = exe_wb_en;
  assign hazard       = |{w_id1_hit, w_id2_hit};
  assign w_unused_fwd = ^{exe_src_1, exe_src_1_vld, exe_src_2, exe_src_2_vld,
                          r_mem_mem_read, r_wb_wb_en, r_wb_dest};
`endif

endmodule

`default_nettype wire

// File: tb/tb_forward_ctrl.sv
// ============================================================================
// Module   : tb_forward_ctrl
// Brief    : Self-checking bench for forward_ctrl (either FORWARDING_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       freeze = 1'b0, flush = 1'b0;
  logic       exe_wb_en = 1'b0, exe_mem_read = 1'b0;
  logic [3:0] exe_dest = '0, exe_src_1 = '0, exe_src_2 = '0;
  logic       exe_src_1_vld = 1'b0, exe_src_2_vld = 1'b0;
  logic [3:0] id_src_1 = '0, id_src_2 = '0;
  logic       id_src_1_vld = 1'b0, id_src_2_vld = 1'b0;
  logic [1:0] sel_src_1, sel_src_2;
  logic       hazard;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  forward_ctrl #(.REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .exe_src_1(exe_src_1), .exe_src_2(exe_src_2),
    .exe_src_1_vld(exe_src_1_vld), .exe_src_2_vld(exe_src_2_vld),
    .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_src_1_vld(id_src_1_vld), .id_src_2_vld(id_src_2_vld),
    .sel_src_1(sel_src_1), .sel_src_2(sel_src_2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  // Behavioural model: a two-entry pipeline of producer tags (MEM, WB).
  typedef struct packed {
    logic       en;
    logic       rd;
    logic [3:0] dest;
  } tag_t;

  tag_t pipe [2];

  initial begin
    pipe[0] = '0;
    pipe[1] = '0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0] = '0;
      pipe[1] = '0;
    end else if (flush) begin
      pipe[1] = pipe[0];
      pipe[0] = '{en: 1'b0, rd: 1'b0, dest: exe_dest};
    end else if (!freeze) begin
      pipe[1] = pipe[0];
      pipe[0] = '{en: exe_wb_en, rd: exe_mem_read, dest: exe_dest};
    end
  end

  function automatic logic [1:0] model_sel(input logic [3:0] s, input logic v);
`ifdef FORWARDING_EN
    if (v && pipe[0].en && !pipe[0].rd && pipe[0].dest == s) return 2'b01;
    if (v && pipe[1].en && pipe[1].dest == s) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic id_blocked(input logic [3:0] s, input logic v);
`ifdef FORWARDING_EN
    return v && exe_wb_en && exe_mem_read && (s == exe_dest);
`else
    return v && ((exe_wb_en && s == exe_dest) || (pipe[0].en && s == pipe[0].dest));
`endif
  endfunction

  function automatic logic model_hazard();
    return id_blocked(id_src_1, id_src_1_vld) || id_blocked(id_src_2, id_src_2_vld);
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel_src_1", sel_src_1, model_sel(exe_src_1, exe_src_1_vld));
      check("model_sel_src_2", sel_src_2, model_sel(exe_src_2, exe_src_2_vld));
      check("model_hazard", {1'b0, hazard}, {1'b0, model_hazard()});
    end
  end

  function automatic logic [1:0] fwd(input logic [1:0] v);
`ifdef FORWARDING_EN
    return v;
`else
    return 2'b00;
`endif
  endfunction

  task automatic set_exe(input logic wb, input logic rd, input logic [3:0] d,
                         input logic [3:0] s1, input logic v1,
                         input logic [3:0] s2, input logic v2);
    exe_wb_en = wb; exe_mem_read = rd; exe_dest = d;
    exe_src_1 = s1; exe_src_1_vld = v1; exe_src_2 = s2; exe_src_2_vld = v2;
  endtask

  task automatic set_id(input logic [3:0] s1, input logic v1,
                        input logic [3:0] s2, input logic v2);
    id_src_1 = s1; id_src_1_vld = v1; id_src_2 = s2; id_src_2_vld = v2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: tags cleared, hazard purely from EXE inputs (load r5, ID reads r5).
    set_exe(1'b1, 1'b1, 4'd5, 4'd0, 1'b1, 4'd0, 1'b1);
    set_id(4'd5, 1'b1, 4'd0, 1'b0);
    #2;
    check("reset_sel_src_1", sel_src_1, 2'b00);
    check("reset_sel_src_2", sel_src_2, 2'b00);
    check("reset_hazard", {1'b0, hazard}, 2'b01);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    chk_en = 1'b1;

    // ADD r3 in EXE.
    set_exe(1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
    set_id(4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    // SUB r3, r3, r4: forwards from MEM.
    set_exe(1'b1, 1'b0, 4'd3, 4'd3, 1'b1, 4'd4, 1'b1);
    #1;
    check("mem_fwd_sel_1", sel_src_1, fwd(2'b01));
    check("mem_fwd_sel_2", sel_src_2, 2'b00);
    check("mem_fwd_hazard", {1'b0, hazard}, 2'b00);
    next_cycle();
    // r3 in MEM and r3 in WB: MEM wins.
    set_exe(1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 4'd3, 1'b1);
    #1;
    check("mem_wins_sel_2", sel_src_2, fwd(2'b01));
    check("mem_wins_sel_1", sel_src_1, 2'b00);
    next_cycle();
    // Producer two instructions back: WB forward.
    set_exe(1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 4'd0, 1'b0);
    #1;
    check("wb_fwd_sel_1", sel_src_1, fwd(2'b10));
    next_cycle();

    // Load-use: LDR r5 in EXE, consumer in ID.
    set_exe(1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
    set_id(4'd5, 1'b1, 4'd0, 1'b0);
    #1;
    check("load_use_hazard", {1'b0, hazard}, 2'b01);
    next_cycle();
    // Bubble in EXE, flushed; load now in MEM.
    set_exe(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    flush = 1'b1;
    #1;
`ifdef FORWARDING_EN
    check("bubble_hazard", {1'b0, hazard}, 2'b00);
`else
    check("bubble_hazard_mem", {1'b0, hazard}, 2'b01);
`endif
    next_cycle();
    flush = 1'b0;
    set_exe(1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0);
    set_id(4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    check("load_consumer_sel_1", sel_src_1, fwd(2'b10));
    next_cycle();

    // Freeze with r7 in MEM.
    set_exe(1'b1, 1'b0, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    freeze = 1'b1;
    set_exe(1'b0, 1'b0, 4'd0, 4'd7, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("freeze_sel_1", sel_src_1, fwd(2'b01));
      next_cycle();
    end
    // Freeze plus flush: MEM invalidated (dest 2), r7 moves to WB.
    flush = 1'b1;
    set_exe(1'b0, 1'b0, 4'd2, 4'd7, 1'b1, 4'd0, 1'b0);
    next_cycle();
    freeze = 1'b0;
    flush = 1'b0;
    set_exe(1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 4'd7, 1'b1);
    #1;
    check("flush_mem_invalid_sel_1", sel_src_1, 2'b00);
    check("flush_wb_advance_sel_2", sel_src_2, fwd(2'b10));
    next_cycle();

    // Asynchronous reset with MEM (r9) and WB (r8) tags valid.
    set_exe(1'b1, 1'b0, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    set_exe(1'b1, 1'b0, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    set_exe(1'b1, 1'b1, 4'd1, 4'd9, 1'b1, 4'd8, 1'b1);
    set_id(4'd1, 1'b1, 4'd0, 1'b0);
    #1;
    check("pre_reset_sel_1", sel_src_1, fwd(2'b01));
    check("pre_reset_sel_2", sel_src_2, fwd(2'b10));
    rst = 1'b0;
    #1;
    check("async_reset_sel_1", sel_src_1, 2'b00);
    check("async_reset_sel_2", sel_src_2, 2'b00);
    exe_wb_en = 1'b0;
    #1;
    check("async_reset_hazard", {1'b0, hazard}, 2'b00);
    next_cycle();
    rst = 1'b1;

    // r3 producer in MEM, ID reads r3; then producer only in WB.
    set_exe(1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
    set_id(4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    set_exe(1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 4'd0, 1'b0);
    set_id(4'd0, 1'b0, 4'd3, 1'b1);
    #1;
    check("id_mem_prod_sel_1", sel_src_1, fwd(2'b01));
`ifdef FORWARDING_EN
    check("id_mem_prod_hazard", {1'b0, hazard}, 2'b00);
`else
    check("id_mem_prod_hazard", {1'b0, hazard}, 2'b01);
`endif
    next_cycle();
    // Invalid ID operand r0 against a load to r0 must not stall.
    set_exe(1'b1, 1'b1, 4'd0, 4'd3, 1'b1, 4'd0, 1'b0);
    set_id(4'd0, 1'b0, 4'd3, 1'b1);
    #1;
    check("id_wb_only_hazard", {1'b0, hazard}, 2'b00);
    check("id_wb_only_sel_1", sel_src_1, fwd(2'b10));
    next_cycle();

    // Randomized traffic over a small register range to force collisions.
    for (int i = 0; i < 2000; i++) begin
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      set_exe(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 1'($urandom),
              4'($urandom_range(0, 3)), 1'($urandom));
      set_id(4'($urandom_range(0, 3)), 1'($urandom),
             4'($urandom_range(0, 3)), 1'($urandom));
      next_cycle();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
